nonce_collector: RTL and testbench

//  Gathers hits from CORES parallel miner cores (found flag + running nonce counter) and rebases each

---
 rtl/nonce_collector.sv | 251 +++++++++++++++++++++++++
 tb/tb_nonce_collector.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_collector.sv
// nonce_collector: rebases per-core miner hits to the winning nonce, round-robin arbitrates them into a result FIFO.
// Latency: hit sampled at edge N is captured at N, pushed at N+1, visible on out_valid after N+1 (FIFO empty).
// Backpressure: out_ready low fills the FIFO; once full, pushes stall, each core keeps one pending hit, further hits are dropped and counted.
//
// Ports:
//   clk, reset_n (async, active-low), clear (sync flush of all state)
//   found_vec[CORES]       per-core hit flag
//   nonce_vec[32*CORES]    per-core running nonce counter, core i at [32*i+31:32*i]
//   out_valid/out_ready    result stream handshake; out_nonce/out_core held while stalled
//   fifo_level             entries currently queued
//   hit_count              results pushed (wraps); drop_count hits lost (saturates)
//   out_tstamp             capture cycle stamp, only with NONCE_COLLECTOR_TSTAMP_EN defined
//
// Build option: define NONCE_COLLECTOR_TSTAMP_EN to add a free-running cycle counter that is
// latched with every hit and carried through the FIFO to out_tstamp.
module nonce_collector #(
   parameter  int CORES = 4,
   parameter  int LAT   = 1,
   parameter  int DEPTH = 8,
   localparam int CW    = (CORES > 1) ? $clog2(CORES) : 1,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clear,
   input  logic [CORES-1:0]    found_vec,
   input  logic [32*CORES-1:0] nonce_vec,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [31:0]         out_nonce,
   output logic [CW-1:0]       out_core,
`ifdef NONCE_COLLECTOR_TSTAMP_EN
   output logic [31:0]         out_tstamp,
`endif
   output logic [LW-1:0]       fifo_level,
   output logic [31:0]         hit_count,
   output logic [15:0]         drop_count
);

   localparam int AW = $clog2(DEPTH);
   // The counter a core reports has already advanced LAT steps of CORES past the hitting nonce.
   localparam logic [31:0] CORR = 32'(LAT * CORES);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [CORES-1:0] r_pend;
   logic [31:0]      r_cap [CORES];
   logic [CW-1:0]    r_rr;

   logic [31:0]      r_mem_nonce [DEPTH];
   logic [CW-1:0]    r_mem_core  [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [LW-1:0]    r_level;
   logic [31:0]      r_hit;
   logic [15:0]      r_drop;

`ifdef NONCE_COLLECTOR_TSTAMP_EN
   logic [31:0]      r_tstamp;
   logic [31:0]      r_cap_ts [CORES];
   logic [31:0]      r_mem_ts [DEPTH];
   logic [31:0]      w_gnt_ts;
`endif

   // ------------------------------------------------------------------
   // Combinational
   // ------------------------------------------------------------------
   logic             w_full;
   logic             w_pop;
   logic             w_gnt_vld;
   logic [CORES-1:0] w_gnt_oh;
   logic [CW-1:0]    w_gnt_idx;
   logic [31:0]      w_gnt_nonce;
   logic [CW-1:0]    w_rr_nxt;
   logic [CORES-1:0] w_cap_en;
   logic [CORES-1:0] w_drop_vec;
   logic [16:0]      w_drop_sum;
   logic [15:0]      w_drop_nxt;

   // Full is judged on registered level: a pop in the same cycle does not free a slot for this push.
   assign w_full = (r_level == LW'(DEPTH));
   assign w_pop  = out_valid && out_ready;

   // Round-robin: first pass covers cores rr..CORES-1, second pass wraps to 0..rr-1
   // (anything the second pass finds is necessarily below rr).
   always_comb begin
      w_gnt_vld   = 1'b0;
      w_gnt_oh    = '0;
      w_gnt_idx   = '0;
      w_gnt_nonce = '0;
      w_rr_nxt    = r_rr;
`ifdef NONCE_COLLECTOR_TSTAMP_EN
      w_gnt_ts    = '0;
`endif
      if (!w_full) begin
         for (int i = 0; i < CORES; i++) begin
            if (!w_gnt_vld && r_pend[i] && (i >= int'(r_rr))) begin
               w_gnt_vld   = 1'b1;
               w_gnt_oh[i] = 1'b1;
               w_gnt_idx   = CW'(i);
               w_gnt_nonce = r_cap[i];
               w_rr_nxt    = (i == CORES - 1) ? '0 : CW'(i + 1);
`ifdef NONCE_COLLECTOR_TSTAMP_EN
               w_gnt_ts    = r_cap_ts[i];
`endif
            end
         end
         for (int i = 0; i < CORES; i++) begin
            if (!w_gnt_vld && r_pend[i]) begin
               w_gnt_vld   = 1'b1;
               w_gnt_oh[i] = 1'b1;
               w_gnt_idx   = CW'(i);
               w_gnt_nonce = r_cap[i];
               w_rr_nxt    = (i == CORES - 1) ? '0 : CW'(i + 1);
`ifdef NONCE_COLLECTOR_TSTAMP_EN
               w_gnt_ts    = r_cap_ts[i];
`endif
            end
         end
      end
   end

   // A core can take a new hit when its slot is free or is being drained this very edge.
   always_comb begin
      w_cap_en   = found_vec & (~r_pend | w_gnt_oh);
      w_drop_vec = found_vec & r_pend & ~w_gnt_oh;
      w_drop_sum = {1'b0, r_drop};
      for (int i = 0; i < CORES; i++) begin
         if (w_drop_vec[i]) begin
            w_drop_sum = w_drop_sum + 17'd1;
         end
      end
      w_drop_nxt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
   end

   // ------------------------------------------------------------------
   // Per-core capture slots and arbiter pointer
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend <= '0;
         r_rr   <= '0;
         r_hit  <= '0;
         r_drop <= '0;
         for (int i = 0; i < CORES; i++) begin
            r_cap[i] <= '0;
         end
      end else if (clear) begin
         r_pend <= '0;
         r_rr   <= '0;
         r_hit  <= '0;
         r_drop <= '0;
         for (int i = 0; i < CORES; i++) begin
            r_cap[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CORES; i++) begin
            if (w_cap_en[i]) begin
               r_pend[i] <= 1'b1;
               r_cap[i]  <= nonce_vec[32*i +: 32] - CORR;
            end else if (w_gnt_oh[i]) begin
               r_pend[i] <= 1'b0;
            end
         end
         if (w_gnt_vld) begin
            r_rr  <= w_rr_nxt;
            r_hit <= r_hit + 32'd1;
         end
         r_drop <= w_drop_nxt;
      end
   end

`ifdef NONCE_COLLECTOR_TSTAMP_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tstamp <= '0;
         for (int i = 0; i < CORES; i++) begin
            r_cap_ts[i] <= '0;
         end
      end else if (clear) begin
         r_tstamp <= '0;
         for (int i = 0; i < CORES; i++) begin
            r_cap_ts[i] <= '0;
         end
      end else begin
         r_tstamp <= r_tstamp + 32'd1;
         for (int i = 0; i < CORES; i++) begin
            if (w_cap_en[i]) begin
               r_cap_ts[i] <= r_tstamp;
            end
         end
      end
   end
`endif

   // ------------------------------------------------------------------
   // Result FIFO: storage is cleared too so outputs read 0 after reset/clear.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_nonce[i] <= '0;
            r_mem_core[i]  <= '0;
`ifdef NONCE_COLLECTOR_TSTAMP_EN
            r_mem_ts[i]    <= '0;
`endif
         end
      end else if (clear) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_nonce[i] <= '0;
            r_mem_core[i]  <= '0;
`ifdef NONCE_COLLECTOR_TSTAMP_EN
            r_mem_ts[i]    <= '0;
`endif
         end
      end else begin
         if (w_gnt_vld) begin
            r_mem_nonce[r_wr] <= w_gnt_nonce;
            r_mem_core[r_wr]  <= w_gnt_idx;
`ifdef NONCE_COLLECTOR_TSTAMP_EN
            r_mem_ts[r_wr]    <= w_gnt_ts;
`endif
            r_wr <= r_wr + AW'(1);
         end
         if (w_pop) begin
            r_rd <= r_rd + AW'(1);
         end
         r_level <= r_level + LW'(w_gnt_vld) - LW'(w_pop);
      end
   end

   // Head is read straight from storage; a write never lands on the head slot while it is
   // occupied, so the head holds steady under backpressure.
   assign out_valid  = (r_level != '0);
   assign out_nonce  = r_mem_nonce[r_rd];
   assign out_core   = r_mem_core[r_rd];
`ifdef NONCE_COLLECTOR_TSTAMP_EN
   assign out_tstamp = r_mem_ts[r_rd];
`endif
   assign fifo_level = r_level;
   assign hit_count  = r_hit;
   assign drop_count = r_drop;

endmodule

// File: tb/tb_nonce_collector.sv
module tb_nonce_collector;
   localparam int CORES = 4;
   localparam int LAT   = 1;
   localparam int DEPTH = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b1;
   logic         clear = 1'b0;
   logic [3:0]   found_vec = '0;
   logic [127:0] nonce_vec = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [31:0]  out_nonce;
   logic [1:0]   out_core;
   logic [3:0]   fifo_level;
   logic [31:0]  hit_count;
   logic [15:0]  drop_count;
`ifdef NONCE_COLLECTOR_TSTAMP_EN
   logic [31:0]  out_tstamp;
`endif

   nonce_collector #(.CORES(CORES), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (clear),
      .found_vec  (found_vec),
      .nonce_vec  (nonce_vec),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_nonce  (out_nonce),
      .out_core   (out_core),
`ifdef NONCE_COLLECTOR_TSTAMP_EN
      .out_tstamp (out_tstamp),
`endif
      .fifo_level (fifo_level),
      .hit_count  (hit_count),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   logic [33:0] sb_q [$];   // {core, corrected nonce}
   logic [33:0] m_exp;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
   endtask

   task automatic expect_res(input int core, input logic [31:0] raw);
      logic [31:0] corr;
      corr = raw - 32'(LAT * CORES);
      sb_q.push_back({2'(core), corr});
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_nonce(input int core, input logic [31:0] v);
      nonce_vec[32*core +: 32] = v;
   endtask

   task automatic wait_drain(input string tag);
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 200) begin
         tick();
         k++;
      end
      chk(tag, 64'(sb_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      sb_q.delete();
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      sb_q.delete();
      tick();
      clear = 1'b0;
   endtask

   // Scoreboard consumer: a handshake seen here completes on the following rising edge.
   always @(negedge clk) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", 64'(sb_q.size()), 64'd1);
         end else begin
            m_exp = sb_q.pop_front();
            chk("out_nonce", 64'(out_nonce), 64'(m_exp[31:0]));
            chk("out_core",  64'(out_core),  64'(m_exp[33:32]));
         end
      end
   end

   initial begin
      // Reset state
      #1 reset_n = 1'b0;
      #2;
      chk("rst_valid", 64'(out_valid),  64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
      chk("rst_hit",   64'(hit_count),  64'd0);
      chk("rst_drop",  64'(drop_count), 64'd0);
      chk("rst_nonce", 64'(out_nonce),  64'd0);
      chk("rst_core",  64'(out_core),   64'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // 1: single hit, two-edge latency
      out_ready = 1'b1;
      found_vec = 4'b0100;
      set_nonce(2, 32'h0000_0107);
      expect_res(2, 32'h0000_0107);
      tick();
      found_vec = '0;
      chk("t1_lat1",  64'(out_valid), 64'd0);
      tick();
      chk("t1_valid", 64'(out_valid), 64'd1);
      chk("t1_hits",  64'(hit_count), 64'd1);
      wait_drain("t1_drain");

      // 2: subtraction wraps below zero
      found_vec = 4'b0001;
      set_nonce(0, 32'h0000_0002);
      expect_res(0, 32'h0000_0002);
      tick();
      found_vec = '0;
      wait_drain("t2_drain");

      // 3: simultaneous hits, two bursts, rr pointer wraps back to 0
      do_clear();
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < CORES; i++) begin
            set_nonce(i, 32'h0000_1000 + 32'(b * 256 + i * 16));
            expect_res(i, 32'h0000_1000 + 32'(b * 256 + i * 16));
         end
         found_vec = 4'hF;
         tick();
         found_vec = '0;
         for (int k = 0; k < CORES; k++) begin
            tick();
            chk("t3_stream", 64'(out_valid), 64'd1);
         end
         tick();
         chk("t3_idle", 64'(out_valid), 64'd0);
         wait_drain("t3_drain");
      end

      // 4: backpressure, overflow and drop counting
      do_reset();
      out_ready = 1'b0;
      found_vec = 4'b0010;
      for (int k = 0; k < 12; k++) begin
         set_nonce(1, 32'h0000_5000 + 32'(4 * k));
         if (k < 9) expect_res(1, 32'h0000_5000 + 32'(4 * k));
         tick();
      end
      found_vec = '0;
      tick(2);
      chk("t4_level", 64'(fifo_level), 64'd8);
      chk("t4_drop",  64'(drop_count), 64'd3);
      chk("t4_hits",  64'(hit_count),  64'd8);
      chk("t4_hold",  64'(out_nonce),  64'h4FFC);
      out_ready = 1'b1;
      wait_drain("t4_drain");
      tick(2);
      chk("t4_hits9", 64'(hit_count),  64'd9);
      chk("t4_empty", 64'(fifo_level), 64'd0);

      // 5: re-capture on the grant edge
      do_clear();
      found_vec = 4'b1000;
      set_nonce(3, 32'h0000_7000);
      expect_res(3, 32'h0000_7000);
      tick();
      set_nonce(3, 32'h0000_7004);
      expect_res(3, 32'h0000_7004);
      tick();
      found_vec = '0;
      wait_drain("t5_drain");
      chk("t5_drop", 64'(drop_count), 64'd0);
      chk("t5_hits", 64'(hit_count),  64'd2);

      // 6a: async reset with entries queued
      out_ready = 1'b0;
      found_vec = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         set_nonce(0, 32'h0000_9000 + 32'(4 * k));
         expect_res(0, 32'h0000_9000 + 32'(4 * k));
         tick();
      end
      found_vec = '0;
      tick(2);
      chk("t6_level5", 64'(fifo_level), 64'd5);
      #2 reset_n = 1'b0;
      sb_q.delete();
      #1;
      chk("t6_rst_valid", 64'(out_valid),  64'd0);
      chk("t6_rst_level", 64'(fifo_level), 64'd0);
      chk("t6_rst_hits",  64'(hit_count),  64'd0);
      tick();
      reset_n = 1'b1;
      tick();
      out_ready = 1'b1;
      found_vec = 4'b0100;
      set_nonce(2, 32'h0000_0020);
      expect_res(2, 32'h0000_0020);
      tick();
      found_vec = '0;
      wait_drain("t6_rst_drain");
      chk("t6_rst_hit1", 64'(hit_count), 64'd1);

      // 6b: synchronous clear with entries queued
      out_ready = 1'b0;
      found_vec = 4'b0001;
      for (int k = 0; k < 5; k++) begin
         set_nonce(0, 32'h0000_A000 + 32'(4 * k));
         tick();
      end
      found_vec = '0;
      tick(2);
      chk("t6_clr_pre", 64'(fifo_level), 64'd5);
      do_clear();
      chk("t6_clr_valid", 64'(out_valid),  64'd0);
      chk("t6_clr_level", 64'(fifo_level), 64'd0);
      chk("t6_clr_hits",  64'(hit_count),  64'd0);
      out_ready = 1'b1;
      found_vec = 4'b1000;
      set_nonce(3, 32'h0000_0040);
      expect_res(3, 32'h0000_0040);
      tick();
      found_vec = '0;
      wait_drain("t6_clr_drain");
      chk("t6_clr_hit1", 64'(hit_count), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
